// File: rtl/adrv9001_serdes_lane_aligner.sv
// Finds the strobe's single rising edge per serdes word, locks onto its phase and realigns every data lane to it.
// One-cycle latency valid_in -> valid_out; no backpressure, every word with valid_in high is consumed.
module adrv9001_serdes_lane_aligner #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 2,
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 2
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH-1:0]             strb_in,
  input  logic                              valid_in,
  input  logic                              relock,
  output logic [NUM_LANES*DATA_WIDTH-1:0]   data_out,
  output logic                              valid_out,
  output logic                              locked,
  output logic [$clog2(DATA_WIDTH)-1:0]     phase,
  output logic                              align_err
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = $clog2(W);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int XW = $clog2(MISS_LIMIT + 1);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0] LOCK_C  = MW'(LOCK_COUNT);
  localparam logic [XW-1:0] MISS_C  = XW'(MISS_LIMIT);

  logic [0:0]             state;
  logic [PW-1:0]          cand;
  logic [MW-1:0]          match_cnt;
  logic [XW-1:0]          miss_cnt;
  logic [NUM_LANES*W-1:0] dprev;
  logic                   sprev;

  logic [W:0]             strb_ext;
  logic [W-1:0]           rise;
  logic [PW-1:0]          rise_pos;
  logic                   word_good;
  logic [PW-1:0]          cand_nxt;
  logic [MW-1:0]          match_nxt;
  logic [XW-1:0]          miss_inc;
  logic [NUM_LANES*W-1:0] aligned;

  assign locked = (state == ST_LOCKED);

  // sprev is the last serial bit of the previous word, so it precedes strb_in's MSB
  assign strb_ext = {sprev, strb_in};

  always_comb begin
    rise = '0;
    for (int p = 0; p < W; p++) begin
      rise[p] = strb_ext[W-1-p] & ~strb_ext[W-p];
    end
  end

  always_comb begin
    rise_pos = '0;
    for (int p = 0; p < W; p++) begin
      if (rise[p]) rise_pos = PW'(p);
    end
  end

  assign word_good = (rise != '0) && ((rise & (rise - ONE_W)) == '0);

  always_comb begin
    cand_nxt  = cand;
    match_nxt = '0;
    if (word_good) begin
      if (rise_pos == cand) begin
        match_nxt = match_cnt + MW'(1);
      end else begin
        cand_nxt  = rise_pos;
        match_nxt = MW'(1);
      end
    end
  end

  assign miss_inc = miss_cnt + XW'(1);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [2*W-1:0] shifted;
    assign shifted = {dprev[g*W +: W], data_in[g*W +: W]} << phase;
    assign aligned[g*W +: W] = shifted[2*W-1 -: W];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_SEARCH;
      cand      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      dprev     <= '0;
      sprev     <= 1'b0;
      phase     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      align_err <= 1'b0;
    end else begin
      align_err <= 1'b0;
      valid_out <= valid_in & locked;
      if (valid_in) begin
        dprev <= data_in;
        sprev <= strb_in[0];
      end
      if (valid_in && locked) data_out <= aligned;

      if (relock) begin
        state     <= ST_SEARCH;
        match_cnt <= '0;
        miss_cnt  <= '0;
      end else if (valid_in) begin
        if (state == ST_SEARCH) begin
          cand      <= cand_nxt;
          match_cnt <= match_nxt;
          if (match_nxt == LOCK_C) begin
            state    <= ST_LOCKED;
            phase    <= cand_nxt;
            miss_cnt <= '0;
          end
        end else begin
          if (word_good && rise_pos == phase) begin
            miss_cnt <= '0;
          end else begin
            align_err <= 1'b1;
            if (miss_inc == MISS_C) begin
              state     <= ST_SEARCH;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              miss_cnt <= miss_inc;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adrv9001_serdes_lane_aligner.sv
// Bench for the lane aligner: fixed vector table, corner-case sequences, then random words against a serial-walk model.
module tb_adrv9001_serdes_lane_aligner;

  localparam int W = 16;
  localparam int L = 2;
  localparam int LOCK = 4;
  localparam int MISS = 2;

  logic           clk;
  logic           rstn;
  logic [L*W-1:0] data_in;
  logic [W-1:0]   strb_in;
  logic           valid_in;
  logic           relock;
  logic [L*W-1:0] data_out;
  logic           valid_out;
  logic           locked;
  logic [3:0]     phase;
  logic           align_err;

  adrv9001_serdes_lane_aligner #(
    .DATA_WIDTH(W), .NUM_LANES(L), .LOCK_COUNT(LOCK), .MISS_LIMIT(MISS)
  ) dut (
    .clk(clk), .rstn(rstn), .data_in(data_in), .strb_in(strb_in),
    .valid_in(valid_in), .relock(relock), .data_out(data_out),
    .valid_out(valid_out), .locked(locked), .phase(phase), .align_err(align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model state, updated once per clock edge
  logic        m_locked;
  int          m_phase, m_cand, m_match, m_miss;
  logic [31:0] m_dprev, m_dout;
  logic        m_sprev, m_vout, m_err;

  task automatic model_reset();
    m_locked = 0; m_phase = 0; m_cand = 0; m_match = 0; m_miss = 0;
    m_dprev = 0; m_dout = 0; m_sprev = 0; m_vout = 0; m_err = 0;
  endtask

  // Walk the strobe bit by bit in serial order, noting every 0->1 transition
  task automatic count_edges(input logic [15:0] s, input logic sp, output int n, output int pos);
    logic prev;
    prev = sp; n = 0; pos = 0;
    for (int p = 0; p < 16; p++) begin
      if (s[15-p] && !prev) begin n++; pos = p; end
      prev = s[15-p];
    end
  endtask

  function automatic logic [15:0] extract(input logic [15:0] prev, input logic [15:0] cur, input int ph);
    logic [31:0] c;
    c = {prev, cur};
    c = c >> (16 - ph);
    return c[15:0];
  endfunction

  task automatic model_step(input logic v, input logic rl, input logic [15:0] s, input logic [31:0] d);
    int n, pos;
    logic good;
    n = 0; pos = 0;
    m_err  = 0;
    m_vout = v && m_locked;
    if (v && m_locked)
      for (int l = 0; l < L; l++) m_dout[l*16 +: 16] = extract(m_dprev[l*16 +: 16], d[l*16 +: 16], m_phase);
    if (v) count_edges(s, m_sprev, n, pos);
    good = (n == 1);
    if (rl) begin
      m_locked = 0; m_match = 0; m_miss = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (!good) m_match = 0;
        else if (pos == m_cand) m_match++;
        else begin m_cand = pos; m_match = 1; end
        if (m_match == LOCK) begin m_locked = 1; m_phase = m_cand; m_miss = 0; end
      end else begin
        if (good && pos == m_phase) m_miss = 0;
        else begin
          m_err = 1;
          m_miss++;
          if (m_miss == MISS) begin m_locked = 0; m_match = 0; m_miss = 0; end
        end
      end
    end
    if (v) begin m_dprev = d; m_sprev = s[0]; end
  endtask

  task automatic step(input logic v, input logic rl, input logic [15:0] s, input logic [31:0] d);
    @(negedge clk);
    valid_in = v; relock = rl; strb_in = s; data_in = d;
    @(posedge clk);
    #1;
    model_step(v, rl, s, d);
    chk("valid_out", {31'b0, valid_out}, {31'b0, m_vout});
    chk("locked",    {31'b0, locked},    {31'b0, m_locked});
    chk("phase",     {28'b0, phase},     32'(m_phase));
    chk("align_err", {31'b0, align_err}, {31'b0, m_err});
    chk("data_out",  data_out,           m_dout);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 0; valid_in = 0; relock = 0;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    rstn = 1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] strb;
    logic [15:0] d0;
    logic        e_locked;
    logic [3:0]  e_phase;
    logic        e_vout;
    logic        e_err;
    logic [15:0] e_d0;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] dbl;
    logic [15:0] s;
    int cur_ph;

    vecs[0] = '{1'b1, 16'h1FE0, 16'h1111, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 16'h1FE0, 16'h2222, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 16'h1FE0, 16'h3333, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 16'h1FE0, 16'hABCD, 1'b1, 4'd3, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 16'h1FE0, 16'h1234, 1'b1, 4'd3, 1'b1, 1'b0, 16'h5E68};
    vecs[5] = '{1'b1, 16'h0000, 16'h5678, 1'b1, 4'd3, 1'b1, 1'b1, 16'h91A2};
    vecs[6] = '{1'b1, 16'h1FE0, 16'h9ABC, 1'b1, 4'd3, 1'b1, 1'b0, 16'hB3C4};
    vecs[7] = '{1'b1, 16'h0000, 16'h0F0F, 1'b1, 4'd3, 1'b1, 1'b1, 16'hD5E0};
    vecs[8] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b1, 16'h7878};
    vecs[9] = '{1'b1, 16'h1FE0, 16'hFFFF, 1'b0, 4'd3, 1'b0, 1'b0, 16'h7878};

    rstn = 0; valid_in = 0; relock = 0; strb_in = 0; data_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out",  data_out, 32'h0);
    chk("rst_valid_out", {31'b0, valid_out}, 32'h0);
    chk("rst_locked",    {31'b0, locked}, 32'h0);
    chk("rst_phase",     {28'b0, phase}, 32'h0);
    chk("rst_align_err", {31'b0, align_err}, 32'h0);
    @(negedge clk);
    rstn = 1;

    // Lock at phase 3, single miss, double miss
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].v, 1'b0, vecs[i].strb, {~vecs[i].d0, vecs[i].d0});
      chk($sformatf("tbl%0d_locked", i), {31'b0, locked},    {31'b0, vecs[i].e_locked});
      chk($sformatf("tbl%0d_phase", i),  {28'b0, phase},     {28'b0, vecs[i].e_phase});
      chk($sformatf("tbl%0d_vout", i),   {31'b0, valid_out}, {31'b0, vecs[i].e_vout});
      chk($sformatf("tbl%0d_err", i),    {31'b0, align_err}, {31'b0, vecs[i].e_err});
      chk($sformatf("tbl%0d_d0", i),     {16'b0, data_out[15:0]}, {16'b0, vecs[i].e_d0});
    end

    // 1-on/15-off strobe locks at the last phase
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0001, $urandom);
    chk("p15_locked", {31'b0, locked}, 32'h1);
    chk("p15_phase",  {28'b0, phase}, 32'd15);

    // Async reset while locked and streaming, then a full relock is needed
    step(1'b1, 1'b0, 16'h0001, $urandom);
    #2;
    rstn = 0;
    #1;
    chk("arst_data_out",  data_out, 32'h0);
    chk("arst_valid_out", {31'b0, valid_out}, 32'h0);
    chk("arst_locked",    {31'b0, locked}, 32'h0);
    chk("arst_phase",     {28'b0, phase}, 32'h0);
    chk("arst_align_err", {31'b0, align_err}, 32'h0);
    model_reset();
    valid_in = 0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'h1FE0, $urandom);
      chk($sformatf("post_rst_locked%0d", i), {31'b0, locked}, {31'b0, (i == 3)});
    end
    step(1'b1, 1'b0, 16'h1FE0, $urandom);
    chk("post_rst_vout", {31'b0, valid_out}, 32'h1);

    // Relock coincident with a good word
    step(1'b1, 1'b1, 16'h1FE0, $urandom);
    chk("relock_locked", {31'b0, locked}, 32'h0);
    chk("relock_err",    {31'b0, align_err}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'h1FE0, $urandom);
      chk($sformatf("relock_again%0d", i), {31'b0, locked}, {31'b0, (i == 3)});
    end

    // Gaps in valid_in during SEARCH
    apply_reset();
    step(1'b1, 1'b0, 16'h1FE0, $urandom);
    step(1'b0, 1'b0, 16'($urandom), $urandom);
    step(1'b0, 1'b0, 16'($urandom), $urandom);
    step(1'b1, 1'b0, 16'h1FE0, $urandom);
    step(1'b1, 1'b0, 16'h1FE0, $urandom);
    chk("gap_locked3", {31'b0, locked}, 32'h0);
    step(1'b1, 1'b0, 16'h1FE0, $urandom);
    chk("gap_locked4", {31'b0, locked}, 32'h1);
    step(1'b0, 1'b0, 16'($urandom), $urandom);
    chk("gap_vout", {31'b0, valid_out}, 32'h0);

    // Random strobe stream with phase changes, noise words and relocks
    apply_reset();
    cur_ph = $urandom_range(0, 15);
    for (int i = 0; i < 2000; i++) begin
      int kind;
      kind = $urandom_range(0, 99);
      if (kind < 5) cur_ph = $urandom_range(0, 15);
      dbl = {16'hFF00, 16'hFF00} >> cur_ph;
      s = (kind >= 5 && kind < 15) ? 16'($urandom) : dbl[15:0];
      step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2, s, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adrv9001_serdes_lane_aligner.md
ADRV9001_SERDES_LANE_ALIGNER -- requirements
Module: adrv9001_serdes_lane_aligner

Interface
REQ-001 Parameter DATA_WIDTH (W), default 16: serdes word width and sample width in bits; power of two, 8..32.
REQ-002 Parameter NUM_LANES (L), default 2: data lanes sharing one strobe, e.g. I and Q.
REQ-003 Parameter LOCK_COUNT, default 4: consecutive agreeing strobe words required to lock.
REQ-004 Parameter MISS_LIMIT, default 2: consecutive bad strobe words in LOCKED that force a return to SEARCH.
REQ-005 Port clk  in  1: single clock; all logic on its rising edge.
REQ-006 Port rstn  in  1: asynchronous, active-low reset.
REQ-007 Port data_in  in  L*W: serdes words; lane n occupies bits [n*W+W-1:n*W]; MSB is the earliest serial bit.
REQ-008 Port strb_in  in  W: strobe serdes word, MSB earliest.
REQ-009 Port valid_in  in  1: data_in and strb_in are valid this cycle.
REQ-010 Port relock  in  1: single-cycle request to discard lock and restart SEARCH.
REQ-011 Port data_out  out  L*W: strobe-aligned samples, same lane packing as data_in.
REQ-012 Port valid_out  out  1: data_out is valid this cycle.
REQ-013 Port locked  out  1: FSM is in LOCKED.
REQ-014 Port phase  out  log2(W): current locked phase.
REQ-015 Port align_err  out  1: one-cycle pulse on each bad strobe word while LOCKED.

Function
REQ-016 The block SHALL register, on each valid_in, the current data words per lane (dprev) and the LSB of strb_in (sprev); these registers SHALL hold when valid_in=0.
REQ-017 Edge detection on each valid word: a rising edge at phase p (0..W-1) exists where strb_in[W-1-p]=1 and its serial predecessor is 0; the predecessor is strb_in[W-p] for p>=1 and sprev for p=0.
REQ-018 A word SHALL be "good at p" if exactly one rising edge exists, at p; zero or more than one edge makes the word "bad".
REQ-019 The FSM SHALL have two states: SEARCH and LOCKED; reset state SEARCH.
REQ-020 SEARCH: a good word at p equal to the candidate SHALL increment match_cnt; a good word at another p SHALL load the candidate with p and set match_cnt=1; a bad word SHALL clear match_cnt.
REQ-021 SEARCH->LOCKED when match_cnt reaches LOCK_COUNT; phase SHALL load the candidate in the same edge; miss_cnt SHALL clear.
REQ-022 LOCKED: a word good at phase SHALL clear miss_cnt; any other word SHALL increment miss_cnt and pulse align_err on the following cycle.
REQ-023 LOCKED->SEARCH when miss_cnt reaches MISS_LIMIT; match_cnt and miss_cnt SHALL clear; phase SHALL hold its last value.
REQ-024 relock=1 SHALL force SEARCH and clear both counters at the next edge, taking priority over valid_in evaluation in that cycle; align_err SHALL not pulse for that word.
REQ-025 Per lane, data_out SHALL equal W bits of the 2W-bit concatenation {dprev, data_in} starting at bit index 2W-1-phase (phase 0 yields dprev), registered one cycle after valid_in.
REQ-026 valid_out SHALL be the registered value of (valid_in AND locked-as-of-that-cycle); latency from valid_in to valid_out SHALL be exactly 1 cycle.
REQ-027 data_out SHALL hold its value in any cycle where valid_out is not asserted.
REQ-028 Gaps in valid_in SHALL neither advance nor clear any counter.

Reset
REQ-029 While rstn=0: data_out=0, valid_out=0, locked=0, phase=0, align_err=0, FSM=SEARCH, counters, dprev and sprev all 0.
REQ-030 Reset deassertion mid-stream SHALL require a full LOCK_COUNT good words before valid_out asserts.

Verification (W=16, L=2, LOCK_COUNT=4, MISS_LIMIT=2)
REQ-031 Assert rstn=0 mid-stream while locked -> all outputs 0 immediately, without waiting for a clock edge.
REQ-032 Four valid words with strb_in=0x1FE0 -> locked=1 and phase=3 after the fourth; then lane0 dprev=0xABCD, data_in=0x1234 -> data_out lane0=0x5E68, valid_out=1 one cycle later.
REQ-033 Repeated strb_in=0x0001 (1-on/15-off) -> lock at phase=15.
REQ-034 While locked at phase 3, one word with strb_in=0x0000 then 0x1FE0 -> single align_err pulse, locked stays 1; two consecutive bad words -> locked=0, valid_out=0 thereafter.
REQ-035 relock=1 coincident with a good valid word while locked -> locked=0 next cycle; four further good words are required to relock.
REQ-036 valid_in toggling 1,0,0,1 during SEARCH -> match_cnt counts only valid words; data_out holds during gaps.
